// File: rtl/sobel_pkg.sv
// Shared types for the Sobel result collector.
// Pixel width, sideband markers and collector FSM states.
package sobel_pkg;

  localparam int PKG_DATA_W = 8;
  localparam int PIX_W = 3 * PKG_DATA_W;

  typedef logic [PIX_W-1:0] pixel_t;

  typedef struct packed {
    logic sof;
    logic eol;
    logic eof;
  } sideband_t;

  typedef enum logic [1:0] {
    IDLE,
    PRIME,
    STREAM,
    DONE
  } collector_state_t;

  function automatic int cw(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pixel_fifo.sv
// Synchronous FIFO, flop storage, no write-to-read bypass.
// A full FIFO still accepts a push when a pop happens in the same cycle.
module pixel_fifo #(
  parameter int DEPTH = 16,
  parameter int W = 27
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [W-1:0]             wdata,
  input  logic                     pop,
  output logic [W-1:0]             rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          do_push, do_pop;

  assign empty = (count_q == '0);
  assign full  = (count_q == (AW+1)'(DEPTH));
  assign count = count_q;
  assign rdata = mem_q[rd_ptr_q];

  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    count_d = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/sobel_stream_collector.sv
// Frames image_processor results into a valid/ready stream
// with sof/eol/eof markers, FIFO buffering and stall feedback.
module sobel_stream_collector
  import sobel_pkg::*;
#(
  parameter int WIDTH      = 100,
  parameter int HEIGHT     = 100,
  parameter int DATA_WIDTH = 8,
  parameter int LATENCY    = WIDTH + 2,
  parameter int FIFO_DEPTH = 16,
  parameter int AF_MARGIN  = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    frame_start,
  input  logic                    shift_en,
  input  logic [3*DATA_WIDTH-1:0] out_pixel,
  output logic [3*DATA_WIDTH-1:0] m_data,
  output logic                    m_valid,
  input  logic                    m_ready,
  output logic                    m_sof,
  output logic                    m_eol,
  output logic                    m_eof,
  output logic                    stall_req,
  output logic                    overflow,
  output logic                    frame_done
);

  localparam int PW  = 3 * DATA_WIDTH;
  localparam int XW  = cw(WIDTH);
  localparam int YW  = cw(HEIGHT);
  localparam int PCW = cw(LATENCY + 1);
  localparam int CW  = $clog2(FIFO_DEPTH) + 1;

  collector_state_t state_q, state_d;
  logic [XW-1:0]    x_q, x_d;
  logic [YW-1:0]    y_q, y_d;
  logic [PCW-1:0]   pcnt_q, pcnt_d;
  logic             overflow_q, overflow_d;
  logic             stall_q, stall_d;
  logic             done_q, done_d;

  logic             sample, push;
  sideband_t        sb, rd_sb;
  logic [PW+2:0]    rdata;
  logic             full, empty;
  logic [CW-1:0]    count, occ_next;
  logic             push_ok, pop_ok;

  assign sample = shift_en && (state_q == PRIME || state_q == STREAM);

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    pcnt_d  = pcnt_q;
    push    = 1'b0;
    sb      = '0;
    // A restart outranks any sample arriving on the same edge.
    if (frame_start) begin
      x_d     = '0;
      y_d     = '0;
      pcnt_d  = '0;
      state_d = (LATENCY == 0) ? STREAM : PRIME;
    end else if (sample) begin
      unique case (state_q)
        PRIME: begin
          pcnt_d = pcnt_q + 1'b1;
          if (pcnt_d == PCW'(LATENCY)) state_d = STREAM;
        end
        STREAM: begin
          push   = 1'b1;
          sb.sof = (x_q == '0) && (y_q == '0);
          sb.eol = (x_q == XW'(WIDTH - 1));
          sb.eof = sb.eol && (y_q == YW'(HEIGHT - 1));
          if (sb.eol) begin
            x_d = '0;
            y_d = sb.eof ? '0 : y_q + 1'b1;
          end else begin
            x_d = x_q + 1'b1;
          end
          if (sb.eof) state_d = DONE;
        end
        default: ;
      endcase
    end
  end

  pixel_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (PW + 3)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .wdata ({out_pixel, sb}),
    .pop   (m_ready),
    .rdata (rdata),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  assign rd_sb   = sideband_t'(rdata[2:0]);
  assign pop_ok  = m_ready && !empty;
  assign push_ok = push && (!full || pop_ok);
  assign occ_next = count + CW'(push_ok) - CW'(pop_ok);

  always_comb begin
    overflow_d = overflow_q | (push && full && !pop_ok);
    stall_d    = (occ_next >= CW'(FIFO_DEPTH - AF_MARGIN));
    done_d     = pop_ok && rd_sb.eof;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      x_q        <= '0;
      y_q        <= '0;
      pcnt_q     <= '0;
      overflow_q <= 1'b0;
      stall_q    <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      x_q        <= x_d;
      y_q        <= y_d;
      pcnt_q     <= pcnt_d;
      overflow_q <= overflow_d;
      stall_q    <= stall_d;
      done_q     <= done_d;
    end
  end

  // Gate with empty so stale storage never leaks onto the bus.
  assign m_valid    = !empty;
  assign m_data     = empty ? '0 : rdata[PW+2:3];
  assign m_sof      = !empty && rd_sb.sof;
  assign m_eol      = !empty && rd_sb.eol;
  assign m_eof      = !empty && rd_sb.eof;
  assign stall_req  = stall_q;
  assign overflow   = overflow_q;
  assign frame_done = done_q;

endmodule

// File: tb/tb_sobel_stream_collector.sv
// Directed bench for sobel_stream_collector on a 4x2 frame,
// LATENCY=6, FIFO_DEPTH=4, AF_MARGIN=1.
module tb_sobel_stream_collector;

  localparam int PW = 24;

  logic          clk = 1'b0;
  logic          rst_n, frame_start, shift_en, m_ready;
  logic [PW-1:0] out_pixel, m_data;
  logic          m_valid, m_sof, m_eol, m_eof;
  logic          stall_req, overflow, frame_done;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int eof_cyc, done_cyc;
  logic [PW-1:0] got_q[$];
  logic [2:0]    got_sb[$];

  always #5 clk = ~clk;

  sobel_stream_collector #(
    .WIDTH      (4),
    .HEIGHT     (2),
    .DATA_WIDTH (8),
    .LATENCY    (6),
    .FIFO_DEPTH (4),
    .AF_MARGIN  (1)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .frame_start (frame_start),
    .shift_en    (shift_en),
    .out_pixel   (out_pixel),
    .m_data      (m_data),
    .m_valid     (m_valid),
    .m_ready     (m_ready),
    .m_sof       (m_sof),
    .m_eol       (m_eol),
    .m_eof       (m_eof),
    .stall_req   (stall_req),
    .overflow    (overflow),
    .frame_done  (frame_done)
  );

  task automatic tick();
    if (m_valid && m_ready) begin
      got_q.push_back(m_data);
      got_sb.push_back({m_sof, m_eol, m_eof});
      if (m_eof) eof_cyc = cyc;
    end
    @(posedge clk);
    #1;
    cyc++;
    if (frame_done) done_cyc = cyc;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    frame_start = 1'b0;
    shift_en = 1'b0;
    m_ready = 1'b0;
    out_pixel = '0;
    tick();
    tick();
    rst_n = 1'b1;
    got_q.delete();
    got_sb.delete();
    eof_cyc = -1;
    done_cyc = -1;
  endtask

  task automatic start_frame();
    frame_start = 1'b1;
    shift_en = 1'b0;
    tick();
    frame_start = 1'b0;
  endtask

  task automatic feed(input int first, input int last);
    for (int i = first; i <= last; i++) begin
      shift_en = 1'b1;
      out_pixel = PW'(i);
      tick();
    end
    shift_en = 1'b0;
  endtask

  task automatic drain(input int n);
    shift_en = 1'b0;
    m_ready = 1'b1;
    repeat (n) tick();
  endtask

  task automatic test_reset();
    do_reset();
    tests++;
    if (m_valid !== 1'b0) begin
      fails++; $display("FAIL reset_valid: got %b want 0", m_valid);
    end
    tests++;
    if (m_data !== '0) begin
      fails++; $display("FAIL reset_data: got %0d want 0", m_data);
    end
    tests++;
    if (stall_req !== 1'b0) begin
      fails++; $display("FAIL reset_stall: got %b want 0", stall_req);
    end
    tests++;
    if (overflow !== 1'b0) begin
      fails++; $display("FAIL reset_ovf: got %b want 0", overflow);
    end
    tests++;
    if (frame_done !== 1'b0) begin
      fails++; $display("FAIL reset_done: got %b want 0", frame_done);
    end
  endtask

  task automatic test_basic();
    logic [2:0] exp_sb;
    do_reset();
    m_ready = 1'b1;
    start_frame();
    feed(0, 13);
    drain(6);
    tests++;
    if (got_q.size() != 8) begin
      fails++; $display("FAIL basic_count: got %0d want 8", got_q.size());
    end
    for (int i = 0; i < 8 && i < got_q.size(); i++) begin
      exp_sb = {i == 0, i == 3 || i == 7, i == 7};
      tests++;
      if (got_q[i] !== PW'(6 + i)) begin
        fails++; $display("FAIL basic_data[%0d]: got %0d want %0d", i, got_q[i], 6 + i);
      end
      tests++;
      if (got_sb[i] !== exp_sb) begin
        fails++; $display("FAIL basic_sb[%0d]: got %b want %b", i, got_sb[i], exp_sb);
      end
    end
    tests++;
    if (eof_cyc < 0 || done_cyc != eof_cyc + 1) begin
      fails++; $display("FAIL basic_done: got cyc %0d want %0d", done_cyc, eof_cyc + 1);
    end
    tests++;
    if (frame_done !== 1'b0) begin
      fails++; $display("FAIL basic_done_pulse: got %b want 0", frame_done);
    end
    tests++;
    if (overflow !== 1'b0) begin
      fails++; $display("FAIL basic_ovf: got %b want 0", overflow);
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    start_frame();
    for (int i = 0; i <= 13; i++) begin
      shift_en = 1'b1;
      out_pixel = PW'(i);
      tick();
      if (i == 7) begin
        tests++;
        if (stall_req !== 1'b0) begin
          fails++; $display("FAIL bp_stall_early: got %b want 0", stall_req);
        end
      end
      if (i == 8) begin
        tests++;
        if (stall_req !== 1'b1) begin
          fails++; $display("FAIL bp_stall: got %b want 1", stall_req);
        end
      end
      if (i == 9) begin
        tests++;
        if (overflow !== 1'b0) begin
          fails++; $display("FAIL bp_ovf_early: got %b want 0", overflow);
        end
      end
      if (i == 10) begin
        tests++;
        if (overflow !== 1'b1) begin
          fails++; $display("FAIL bp_ovf: got %b want 1", overflow);
        end
      end
    end
    tests++;
    if (m_valid !== 1'b1 || m_data !== PW'(6)) begin
      fails++; $display("FAIL bp_hold: got v=%b d=%0d want v=1 d=6", m_valid, m_data);
    end
    drain(8);
    tests++;
    if (got_q.size() != 4) begin
      fails++; $display("FAIL bp_count: got %0d want 4", got_q.size());
    end
    for (int i = 0; i < 4 && i < got_q.size(); i++) begin
      tests++;
      if (got_q[i] !== PW'(6 + i)) begin
        fails++; $display("FAIL bp_data[%0d]: got %0d want %0d", i, got_q[i], 6 + i);
      end
    end
    tests++;
    if (overflow !== 1'b1) begin
      fails++; $display("FAIL bp_ovf_sticky: got %b want 1", overflow);
    end
  endtask

  task automatic test_full_push_pop();
    do_reset();
    start_frame();
    feed(0, 9);
    tests++;
    if (stall_req !== 1'b1) begin
      fails++; $display("FAIL fpp_stall_full: got %b want 1", stall_req);
    end
    m_ready = 1'b1;
    shift_en = 1'b1;
    out_pixel = PW'(10);
    tick();
    tests++;
    if (overflow !== 1'b0) begin
      fails++; $display("FAIL fpp_ovf: got %b want 0", overflow);
    end
    tests++;
    if (stall_req !== 1'b1) begin
      fails++; $display("FAIL fpp_stall: got %b want 1", stall_req);
    end
    tests++;
    if (m_data !== PW'(7)) begin
      fails++; $display("FAIL fpp_head: got %0d want 7", m_data);
    end
    drain(8);
    tests++;
    if (got_q.size() != 5) begin
      fails++; $display("FAIL fpp_count: got %0d want 5", got_q.size());
    end
    for (int i = 0; i < 5 && i < got_q.size(); i++) begin
      tests++;
      if (got_q[i] !== PW'(6 + i)) begin
        fails++; $display("FAIL fpp_data[%0d]: got %0d want %0d", i, got_q[i], 6 + i);
      end
    end
  endtask

  task automatic test_prime_gaps();
    do_reset();
    m_ready = 1'b1;
    start_frame();
    for (int j = 0; j < 30; j++) begin
      shift_en = (j % 2 == 0);
      out_pixel = PW'(50 + j);
      tick();
    end
    drain(4);
    tests++;
    if (got_q.size() < 2 || got_q[0] !== PW'(62)) begin
      fails++; $display("FAIL gap_first: got %0d want 62", got_q.size() > 0 ? got_q[0] : '1);
    end
    tests++;
    if (got_q.size() < 2 || got_q[1] !== PW'(64)) begin
      fails++; $display("FAIL gap_second: got %0d want 64", got_q.size() > 1 ? got_q[1] : '1);
    end
    tests++;
    if (got_sb.size() < 1 || got_sb[0] !== 3'b100) begin
      fails++; $display("FAIL gap_sof: got %b want 100", got_sb.size() > 0 ? got_sb[0] : 3'bxxx);
    end
  endtask

  task automatic test_reset_mid();
    int seen = 0;
    do_reset();
    start_frame();
    feed(0, 8);
    tests++;
    if (stall_req !== 1'b1) begin
      fails++; $display("FAIL rst_pre_stall: got %b want 1", stall_req);
    end
    rst_n = 1'b0;
    shift_en = 1'b1;
    out_pixel = PW'(99);
    tick();
    rst_n = 1'b1;
    tests++;
    if (m_valid !== 1'b0 || stall_req !== 1'b0 || overflow !== 1'b0) begin
      fails++; $display("FAIL rst_mid: got v=%b s=%b o=%b want 0 0 0", m_valid, stall_req, overflow);
    end
    m_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      shift_en = 1'b1;
      out_pixel = PW'(200 + k);
      tick();
      if (m_valid) seen++;
    end
    tests++;
    if (seen != 0 || got_q.size() != 0) begin
      fails++; $display("FAIL rst_ignore: got %0d valid cycles want 0", seen);
    end
  endtask

  task automatic test_restart();
    do_reset();
    start_frame();
    feed(0, 8);
    frame_start = 1'b1;
    shift_en = 1'b1;
    out_pixel = PW'(9);
    tick();
    frame_start = 1'b0;
    m_ready = 1'b1;
    feed(10, 16);
    drain(6);
    tests++;
    if (got_q.size() != 4) begin
      fails++; $display("FAIL rs_count: got %0d want 4", got_q.size());
    end
    if (got_q.size() == 4) begin
      tests++;
      if (got_q[0] !== PW'(6) || got_q[1] !== PW'(7) || got_q[2] !== PW'(8)) begin
        fails++; $display("FAIL rs_old: got %0d %0d %0d want 6 7 8", got_q[0], got_q[1], got_q[2]);
      end
      tests++;
      if (got_q[3] !== PW'(16)) begin
        fails++; $display("FAIL rs_new: got %0d want 16", got_q[3]);
      end
      tests++;
      if (got_sb[3][2] !== 1'b1 || got_sb[1][2] !== 1'b0) begin
        fails++; $display("FAIL rs_sof: got %b/%b want 1/0", got_sb[3][2], got_sb[1][2]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_full_push_pop();
    test_prime_gaps();
    test_reset_mid();
    test_restart();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule
